alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 47 ++++
 rtl/alu_control_unit.sv | 52 +++++
 tb/tb_alu_control_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation classes from main control, R-type funct codes,
// and the 4-bit ALU operation selects used by both the control unit and the ALU.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_XOR = 4'b1101;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of {ALUOp, funct} into an ALU operation select.
// Anything not decodable yields CTRL_ILL with illegal raised.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] ins,
  input  logic [1:0] aluop,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_ILL;
    illegal = 1'b1;
    case (aluop)
      ALUOP_ADD: begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
      end
      ALUOP_SUB: begin
        ctrl    = CTRL_SUB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        illegal = 1'b0;
        case (ins)
          FN_ADD, FN_ADDU: ctrl = CTRL_ADD;
          FN_SUB, FN_SUBU: ctrl = CTRL_SUB;
          FN_AND:          ctrl = CTRL_AND;
          FN_OR:           ctrl = CTRL_OR;
          FN_XOR:          ctrl = CTRL_XOR;
          FN_NOR:          ctrl = CTRL_NOR;
          FN_SLT, FN_SLTU: ctrl = CTRL_SLT;
          default: begin
            ctrl    = CTRL_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl    = CTRL_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// ALU control unit: funct/ALUOp decode with an optional one-cycle output register.
// With OUT_REG=0 the outputs are the raw decode and clk/rst_n are ignored.
module alu_control_unit
  import alu_pkg::*;
#(
  parameter bit OUT_REG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ins,
  input  logic [1:0] ALUOp,
  output logic [3:0] ALUctrl,
  output logic       illegal
);

  logic [3:0] ctrl_next;
  logic       illegal_next;

  alu_ctrl_decode u_decode (
    .ins     (ins),
    .aluop   (ALUOp),
    .ctrl    (ctrl_next),
    .illegal (illegal_next)
  );

  generate
    if (OUT_REG) begin : g_reg
      logic [3:0] ctrl_reg;
      logic       illegal_reg;

      // Async clear so a reset mid-cycle drops any pending decode at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_reg    <= CTRL_AND;
          illegal_reg <= 1'b0;
        end else begin
          ctrl_reg    <= ctrl_next;
          illegal_reg <= illegal_next;
        end
      end

      assign ALUctrl = ctrl_reg;
      assign illegal = illegal_reg;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign ALUctrl = ctrl_next;
      assign illegal = illegal_next;
    end
  endgenerate

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed checks of the ALU control unit in both combinational (u_comb)
// and registered (u_reg) builds; one line printed per transaction.
module tb_alu_control_unit;

  logic       clk;
  logic       rst_n_c, rst_n_r;
  logic [5:0] ins_c, ins_r;
  logic [1:0] op_c, op_r;
  logic [3:0] ctrl_c, ctrl_r;
  logic       ill_c, ill_r;

  int total = 0;
  int bad   = 0;

  alu_control_unit #(.OUT_REG(1'b0)) u_comb (
    .clk     (clk),
    .rst_n   (rst_n_c),
    .ins     (ins_c),
    .ALUOp   (op_c),
    .ALUctrl (ctrl_c),
    .illegal (ill_c)
  );

  alu_control_unit #(.OUT_REG(1'b1)) u_reg (
    .clk     (clk),
    .rst_n   (rst_n_r),
    .ins     (ins_r),
    .ALUOp   (op_r),
    .ALUctrl (ctrl_r),
    .illegal (ill_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n_r = 1'b0;
    op_r    = 2'b10;
    ins_r   = 6'b100010;
    #2;
    total++;
    if (ctrl_r !== 4'b0000 || ill_r !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got %b/%b want 0000/0", ctrl_r, ill_r);
    end
    $display("reset: ALUctrl=%b illegal=%b", ctrl_r, ill_r);
    // Clock edges while held in reset must not load the decode.
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ctrl_r !== 4'b0000 || ill_r !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got %b/%b want 0000/0", ctrl_r, ill_r);
    end
    $display("reset held over edges: ALUctrl=%b illegal=%b", ctrl_r, ill_r);
  endtask

  task automatic test_fixed_classes();
    op_c  = 2'b00;
    ins_c = 6'bxxxxxx;
    #1;
    total++;
    if (ctrl_c !== 4'b0010 || ill_c !== 1'b0) begin
      bad++;
      $display("FAIL op00: got %b/%b want 0010/0", ctrl_c, ill_c);
    end
    $display("ALUOp=00 ins=x: ALUctrl=%b illegal=%b", ctrl_c, ill_c);
    op_c  = 2'b01;
    ins_c = 6'b100100;
    #1;
    total++;
    if (ctrl_c !== 4'b0110 || ill_c !== 1'b0) begin
      bad++;
      $display("FAIL op01: got %b/%b want 0110/0", ctrl_c, ill_c);
    end
    $display("ALUOp=01: ALUctrl=%b illegal=%b", ctrl_c, ill_c);
  endtask

  task automatic test_rtype();
    logic [5:0] fns  [0:9];
    logic [3:0] exps [0:9];
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
             6'b100111, 6'b100110, 6'b100001, 6'b100011, 6'b101011};
    exps = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
             4'b1100, 4'b1101, 4'b0010, 4'b0110, 4'b0111};
    op_c = 2'b10;
    for (int i = 0; i < 10; i++) begin
      ins_c = fns[i];
      #1;
      total++;
      if (ctrl_c !== exps[i] || ill_c !== 1'b0) begin
        bad++;
        $display("FAIL rtype_%b: got %b/%b want %b/0", fns[i], ctrl_c, ill_c, exps[i]);
      end
      $display("R-type funct=%b: ALUctrl=%b illegal=%b", fns[i], ctrl_c, ill_c);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops [0:3];
    logic [5:0] fns [0:3];
    ops = '{2'b10, 2'b10, 2'b11, 2'b11};
    fns = '{6'b000000, 6'b101000, 6'b100000, 6'b101010};
    for (int i = 0; i < 4; i++) begin
      op_c  = ops[i];
      ins_c = fns[i];
      #1;
      total++;
      if (ctrl_c !== 4'b1111 || ill_c !== 1'b1) begin
        bad++;
        $display("FAIL illegal_%b_%b: got %b/%b want 1111/1", ops[i], fns[i], ctrl_c, ill_c);
      end
      $display("ALUOp=%b funct=%b: ALUctrl=%b illegal=%b", ops[i], fns[i], ctrl_c, ill_c);
    end
  endtask

  task automatic test_registered_latency();
    @(negedge clk);
    rst_n_r = 1'b1;
    op_r    = 2'b10;
    ins_r   = 6'b100010;
    #1;
    total++;
    if (ctrl_r !== 4'b0000) begin
      bad++;
      $display("FAIL reg_early: got %b want 0000 before edge", ctrl_r);
    end
    @(posedge clk);
    #1;
    total++;
    if (ctrl_r !== 4'b0110 || ill_r !== 1'b0) begin
      bad++;
      $display("FAIL reg_latency: got %b/%b want 0110/0", ctrl_r, ill_r);
    end
    $display("registered sub after one edge: ALUctrl=%b illegal=%b", ctrl_r, ill_r);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops  [0:3];
    logic [5:0] fns  [0:3];
    logic [3:0] exps [0:3];
    logic       ills [0:3];
    ops  = '{2'b00, 2'b11, 2'b10, 2'b10};
    fns  = '{6'b000000, 6'b000000, 6'b100101, 6'b101010};
    exps = '{4'b0010, 4'b1111, 4'b0001, 4'b0111};
    ills = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_r  = ops[i];
      ins_r = fns[i];
      @(posedge clk);
      #1;
      total++;
      if (ctrl_r !== exps[i] || ill_r !== ills[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got %b/%b want %b/%b", i, ctrl_r, ill_r, exps[i], ills[i]);
      end
      $display("registered ALUOp=%b funct=%b: ALUctrl=%b illegal=%b", ops[i], fns[i], ctrl_r, ill_r);
    end
  endtask

  task automatic test_async_reset();
    // Output sits at slt (0111) from the last back-to-back vector.
    #1;
    rst_n_r = 1'b0;
    #1;
    total++;
    if (ctrl_r !== 4'b0000 || ill_r !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got %b/%b want 0000/0", ctrl_r, ill_r);
    end
    $display("mid-cycle reset: ALUctrl=%b illegal=%b", ctrl_r, ill_r);
    @(negedge clk);
    rst_n_r = 1'b1;
    op_r    = 2'b11;
    @(posedge clk);
    #1;
    total++;
    if (ctrl_r !== 4'b1111 || ill_r !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got %b/%b want 1111/1", ctrl_r, ill_r);
    end
    $display("after reset release ALUOp=11: ALUctrl=%b illegal=%b", ctrl_r, ill_r);
  endtask

  initial begin
    rst_n_c = 1'b1;
    rst_n_r = 1'b0;
    ins_c   = 6'b0;
    op_c    = 2'b00;
    ins_r   = 6'b0;
    op_r    = 2'b00;
    test_reset();
    test_fixed_classes();
    test_rtype();
    test_illegal();
    test_registered_latency();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
